// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: multi-cycle WIDTH-bit adder. One shared 2-bit ripple slice
// (two full-adder cells) is stepped across the operands, least-significant
// digit first. A registered carry links the steps. A START/BUSY/DONE
// handshake frames each operation.
module add_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             CO
);

  localparam int STEPS = WIDTH / 2;
  localparam int CNT_W = $clog2(STEPS + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_s_sh;
  logic               r_cr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_done;
  logic [WIDTH-1:0]   r_s;
  logic               r_co;

  logic               w_c0;
  logic [1:0]         w_sl;
  logic               w_sc;
  logic               w_last;
  logic [WIDTH+1:0]   w_s_cat;
  logic [WIDTH-1:0]   w_s_next;

  // 2-bit slice built from two full-adder cells, fed by the registered carry.
  assign w_sl[0] = r_a_sh[0] ^ r_b_sh[0] ^ r_cr;
  assign w_c0    = (r_a_sh[0] & r_b_sh[0]) | (r_cr & (r_a_sh[0] ^ r_b_sh[0]));
  assign w_sl[1] = r_a_sh[1] ^ r_b_sh[1] ^ w_c0;
  assign w_sc    = (r_a_sh[1] & r_b_sh[1]) | (w_c0 & (r_a_sh[1] ^ r_b_sh[1]));

  // New slice digit enters at the top of the accumulator; the concatenation
  // keeps the expression legal when WIDTH = 2.
  assign w_s_cat  = {w_sl, r_s_sh};
  assign w_s_next = w_s_cat[WIDTH+1:2];

  assign w_last = (r_state == RUN) && (r_cnt == CNT_W'(1));

  // Outputs come straight from flops (BUSY decodes the state register).
  assign BUSY = (r_state == RUN);
  assign DONE = r_done;
  assign S    = r_s;
  assign CO   = r_co;

  // State register with synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of block ordering.
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode: accept START in IDLE, leave RUN after the last step.
  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = r_state;
    case (r_state)
      IDLE:    if (START)  w_next = RUN;
      RUN:     if (w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: load operands on accept, step the slice in RUN, publish result.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: the shift registers are reset too so an aborted run leaves no
      // stale operand or carry bits behind.
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_s_sh <= '0;
      r_cr   <= 1'b0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_s    <= '0;
      r_co   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (START) begin
          r_a_sh <= A;
          r_b_sh <= B;
          r_cr   <= CI;
          r_s_sh <= '0;
          r_cnt  <= CNT_W'(STEPS);
        end
      end else begin
        r_a_sh <= r_a_sh >> 2;
        r_b_sh <= r_b_sh >> 2;
        r_s_sh <= w_s_next;
        r_cr   <= w_sc;
        r_cnt  <= r_cnt - CNT_W'(1);
        if (w_last) begin
          r_s    <= w_s_next;
          r_co   <= w_sc;
          r_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl: an 8-bit and a 2-bit instance,
// checked against plain integer addition and the handshake timing rules.
module tb_add_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  // WIDTH = 8 instance
  logic       start8;
  logic [7:0] a8, b8;
  logic       ci8;
  logic       busy8, done8, co8;
  logic [7:0] s8;
  // WIDTH = 2 instance
  logic       start2;
  logic [1:0] a2, b2;
  logic       ci2;
  logic       busy2, done2, co2;
  logic [1:0] s2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  add_seq_ctrl #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST(rst), .START(start8), .A(a8), .B(b8), .CI(ci8),
    .BUSY(busy8), .DONE(done8), .S(s8), .CO(co8)
  );

  add_seq_ctrl #(.WIDTH(2)) dut2 (
    .CLK(clk), .RST(rst), .START(start2), .A(a2), .B(b2), .CI(ci2),
    .BUSY(busy2), .DONE(done2), .S(s2), .CO(co2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation on the 8-bit instance and report what was observed.
  // Operands are scrambled right after acceptance; they must not matter.
  task automatic do_add8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                         output logic [7:0] s, output logic co, output int lat,
                         output int busy_cyc, output bit hold_ok,
                         output logic busy_at_done, output logic done_after);
    logic [7:0] s_prev;
    logic       co_prev;
    s_prev  = s8;
    co_prev = co8;
    a8 = a; b8 = b; ci8 = ci; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
    lat = 0; busy_cyc = 0; hold_ok = 1'b1;
    while (done8 !== 1'b1 && lat < 20) begin
      if (busy8 === 1'b1) busy_cyc++;
      if (s8 !== s_prev || co8 !== co_prev) hold_ok = 1'b0;
      tick();
      lat++;
    end
    s = s8;
    co = co8;
    busy_at_done = busy8;
    tick();
    done_after = done8;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; ci2 = 1'b0;
    tick(); tick();
    total++; if ({busy8, done8, co8, s8} !== 11'd0) begin bad++;
      $display("FAIL reset8 got busy=%b done=%b co=%b s=%h want all 0", busy8, done8, co8, s8); end
    total++; if ({busy2, done2, co2, s2} !== 5'd0) begin bad++;
      $display("FAIL reset2 got busy=%b done=%b co=%b s=%h want all 0", busy2, done2, co2, s2); end
    // Reset wins over a simultaneous START.
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
    tick();
    total++; if (busy8 !== 1'b0) begin bad++;
      $display("FAIL rst_prio busy=%b want 0", busy8); end
    rst = 1'b0; start8 = 1'b0;
    tick();
    total++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin bad++;
      $display("FAIL idle_after_rst busy=%b done=%b want 0 0", busy8, done8); end
  endtask

  task automatic run_directed(input string name, input logic [7:0] a, input logic [7:0] b,
                              input logic ci);
    logic [7:0] s; logic co; int lat, bc; bit hold; logic bad_busy, dn;
    logic [8:0] exp;
    exp = 9'(a) + 9'(b) + 9'(ci);
    do_add8(a, b, ci, s, co, lat, bc, hold, bad_busy, dn);
    total++; if ({co, s} !== exp) begin bad++;
      $display("FAIL %s result got co=%b s=%h want co=%b s=%h", name, co, s, exp[8], exp[7:0]); end
    total++; if (lat !== 4 || bc !== 4) begin bad++;
      $display("FAIL %s timing got latency=%0d busy_cycles=%0d want 4 4", name, lat, bc); end
    total++; if (bad_busy !== 1'b0 || dn !== 1'b0) begin bad++;
      $display("FAIL %s done_cycle busy=%b next_done=%b want 0 0", name, bad_busy, dn); end
    total++; if (hold !== 1'b1) begin bad++;
      $display("FAIL %s hold S/CO changed during RUN want held", name); end
  endtask

  task automatic test_directed();
    run_directed("basic",  8'h5A, 8'h33, 1'b0);
    run_directed("ripple", 8'hFF, 8'h01, 1'b0);
    run_directed("full",   8'hFF, 8'hFF, 1'b1);
  endtask

  task automatic test_random();
    logic [7:0] a, b, s; logic ci, co; int lat, bc; bit hold; logic bd, dn;
    logic [8:0] exp;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
      exp = 9'(a) + 9'(b) + 9'(ci);
      do_add8(a, b, ci, s, co, lat, bc, hold, bd, dn);
      total++; if ({co, s} !== exp || lat !== 4 || bc !== 4 || hold !== 1'b1 || bd !== 1'b0 || dn !== 1'b0) begin
        bad++;
        $display("FAIL rand%0d %h+%h+%b got co=%b s=%h lat=%0d busy=%0d hold=%b want co=%b s=%h lat=4 busy=4 hold=1",
                 i, a, b, ci, co, s, lat, bc, hold, exp[8], exp[7:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    a8 = 8'h10; b8 = 8'h20; ci8 = 1'b0; start8 = 1'b1;
    tick();                                   // accepting edge k
    tick(); tick();                           // k+2
    a8 = 8'h03; b8 = 8'h04;                   // changed mid-run
    tick(); tick();                           // k+4: DONE cycle
    total++; if (done8 !== 1'b1 || busy8 !== 1'b0 || s8 !== 8'h30 || co8 !== 1'b0) begin bad++;
      $display("FAIL b2b_first done=%b busy=%b s=%h co=%b want 1 0 30 0", done8, busy8, s8, co8); end
    if (done8 === 1'b1) dones++;
    tick();                                   // k+5: second accept
    total++; if (busy8 !== 1'b1 || done8 !== 1'b0) begin bad++;
      $display("FAIL b2b_accept busy=%b done=%b want 1 0", busy8, done8); end
    start8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done8 === 1'b1) dones++;
    end                                       // k+9
    total++; if (done8 !== 1'b1 || s8 !== 8'h07 || co8 !== 1'b0) begin bad++;
      $display("FAIL b2b_second done=%b s=%h co=%b want 1 07 0", done8, s8, co8); end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done8 === 1'b1) dones++;
    end
    total++; if (dones !== 2 || busy8 !== 1'b0) begin bad++;
      $display("FAIL b2b_count dones=%0d busy=%b want 2 0", dones, busy8); end
  endtask

  task automatic test_reset_mid_run();
    int dones = 0;
    logic [7:0] s; logic co; int lat, bc; bit hold; logic bd, dn;
    a8 = 8'hAA; b8 = 8'h55; ci8 = 1'b0; start8 = 1'b1;
    tick();                                   // k
    start8 = 1'b0;
    tick();                                   // k+1
    rst = 1'b1;
    tick();                                   // k+2 with reset
    rst = 1'b0;
    total++; if ({busy8, done8, co8, s8} !== 11'd0) begin bad++;
      $display("FAIL rst_mid got busy=%b done=%b co=%b s=%h want all 0", busy8, done8, co8, s8); end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done8 === 1'b1) dones++;
    end
    total++; if (dones !== 0) begin bad++;
      $display("FAIL rst_nodone dones=%0d want 0", dones); end
    do_add8(8'h01, 8'h01, 1'b0, s, co, lat, bc, hold, bd, dn);
    total++; if (s !== 8'h02 || co !== 1'b0 || lat !== 4) begin bad++;
      $display("FAIL rst_after s=%h co=%b lat=%0d want 02 0 4", s, co, lat); end
  endtask

  task automatic test_width2();
    logic [2:0] exp;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 2; c++) begin
          exp = 3'(a) + 3'(b) + 3'(c);
          a2 = 2'(a); b2 = 2'(b); ci2 = 1'(c); start2 = 1'b1;
          tick();                             // accepting edge
          start2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom);
          total++; if (busy2 !== 1'b1 || done2 !== 1'b0) begin bad++;
            $display("FAIL w2_busy %0d+%0d+%0d busy=%b done=%b want 1 0", a, b, c, busy2, done2); end
          tick();
          total++; if (done2 !== 1'b1 || busy2 !== 1'b0 || {co2, s2} !== exp) begin bad++;
            $display("FAIL w2_result %0d+%0d+%0d done=%b busy=%b co=%b s=%0d want 1 0 %0d",
                     a, b, c, done2, busy2, co2, s2, exp); end
          tick();
          total++; if (done2 !== 1'b0) begin bad++;
            $display("FAIL w2_pulse done=%b want 0", done2); end
        end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    test_width2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
